// File: rtl/rex_pkg.sv
// Shared Rex Runner definitions used by the game centre, the draw scheduler and
// the GPU: draw opcodes, game-state encodings, default screen geometry and the
// scheduler FSM state type.
// Optional feature macro: REX_SCORE_DRAW_EN adds the DIGIT state for the score.
package rex_pkg;

  // GPU draw opcodes
  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_HLINE = 3'd1;
  localparam logic [2:0] OP_DINO  = 3'd2;
  localparam logic [2:0] OP_OBST  = 3'd3;
  localparam logic [2:0] OP_OVER  = 3'd4;
  localparam logic [2:0] OP_DIGIT = 3'd5;

  // Game-centre state encodings
  localparam logic [1:0] GS_INIT = 2'd0;
  localparam logic [1:0] GS_GO   = 2'd1;
  localparam logic [1:0] GS_JUMP = 2'd2;
  localparam logic [1:0] GS_OVER = 2'd3;

  // Default screen geometry in pixels
  localparam int DEF_SCREEN_W = 256;
  localparam int DEF_GROUND_Y = 200;
  localparam int DEF_DINO_X   = 16;
  localparam int DEF_DINO_W   = 16;
  localparam int DEF_DINO_H   = 16;
  localparam int DEF_OBST_W   = 16;
  localparam int DEF_OBST_H   = 26;

  // Game-over banner and score digit cell sizes
  localparam int OVER_W   = 64;
  localparam int OVER_H   = 16;
  localparam int DIGIT_SZ = 8;

  // Scheduler FSM states, one draw command per non-idle state
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GROUND,
    S_DINO,
    S_OBST,
`ifdef REX_SCORE_DRAW_EN
    S_OVER,
    S_DIGIT
`else
    S_OVER
`endif
  } draw_state_t;

endpackage

// File: rtl/rex_geom.sv
// Combinational screen-space geometry for one draw command. Maps the scheduler
// state plus the latched frame snapshot to {opcode, x, y, w, h, arg}.
// Optional feature macro: REX_SCORE_DRAW_EN adds score digit geometry.
module rex_geom
  import rex_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int GROUND_Y = DEF_GROUND_Y,
  parameter int DINO_X   = DEF_DINO_X,
  parameter int DINO_W   = DEF_DINO_W,
  parameter int DINO_H   = DEF_DINO_H,
  parameter int OBST_W   = DEF_OBST_W,
  parameter int OBST_H   = DEF_OBST_H
) (
  input  draw_state_t st,
  input  logic [15:0] snap_dino_y,
  input  logic [15:0] snap_obst_x,
`ifdef REX_SCORE_DRAW_EN
  input  logic [1:0]  dig_idx,
  input  logic [15:0] snap_score,
`endif
  output logic [2:0]  op,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] w,
  output logic [15:0] h,
  output logic [3:0]  arg
);

  localparam logic [15:0] SW       = 16'(SCREEN_W);
  localparam logic [15:0] GY       = 16'(GROUND_Y);
  localparam logic [15:0] DX       = 16'(DINO_X);
  localparam logic [15:0] DW       = 16'(DINO_W);
  localparam logic [15:0] DH       = 16'(DINO_H);
  localparam logic [15:0] OW       = 16'(OBST_W);
  localparam logic [15:0] OH       = 16'(OBST_H);
  // Highest jump that still keeps the dino's top edge on screen
  localparam logic [15:0] DINO_TOP = GY - DH;
  localparam logic [15:0] OBST_Y   = GY - OH;
  localparam logic [15:0] OVER_X   = (SW >> 1) - 16'(OVER_W / 2);
  localparam logic [15:0] OVER_Y   = GY >> 1;

  // Limit the jump height so the subtraction below cannot wrap past row 0
  function automatic logic [15:0] clamp_dino(input logic [15:0] dy);
    return (dy > DINO_TOP) ? DINO_TOP : dy;
  endfunction

  // Obstacle width trimmed at the right screen edge; zero when fully off screen
  function automatic logic [15:0] clip_obst_w(input logic [15:0] ox);
    logic [15:0] room;
    if (ox >= SW) return 16'd0;
    room = SW - ox;
    return (room < OW) ? room : OW;
  endfunction

`ifdef REX_SCORE_DRAW_EN
  // Digit 0 is the most significant BCD nibble
  function automatic logic [3:0] bcd_digit(input logic [15:0] sc, input logic [1:0] idx);
    case (idx)
      2'd0:    return sc[15:12];
      2'd1:    return sc[11:8];
      2'd2:    return sc[7:4];
      default: return sc[3:0];
    endcase
  endfunction
`endif

  // Command fields for the given scheduler state; idle yields all zeros
  always_comb begin
    op  = OP_CLEAR;
    x   = 16'd0;
    y   = 16'd0;
    w   = 16'd0;
    h   = 16'd0;
    arg = 4'd0;
    case (st)
      S_CLEAR: begin
        w = SW;
        h = GY;
      end
      S_GROUND: begin
        op = OP_HLINE;
        y  = GY;
        w  = SW;
        h  = 16'd1;
      end
      S_DINO: begin
        op = OP_DINO;
        x  = DX;
        y  = DINO_TOP - clamp_dino(snap_dino_y);
        w  = DW;
        h  = DH;
      end
      S_OBST: begin
        op = OP_OBST;
        x  = snap_obst_x;
        y  = OBST_Y;
        w  = clip_obst_w(snap_obst_x);
        h  = OH;
      end
      S_OVER: begin
        op = OP_OVER;
        x  = OVER_X;
        y  = OVER_Y;
        w  = 16'(OVER_W);
        h  = 16'(OVER_H);
      end
`ifdef REX_SCORE_DRAW_EN
      S_DIGIT: begin
        // Four cells packed against an 8-pixel right margin
        op  = OP_DIGIT;
        x   = SW - 16'd40 + {11'd0, dig_idx, 3'd0};
        y   = 16'(DIGIT_SZ);
        w   = 16'(DIGIT_SZ);
        h   = 16'(DIGIT_SZ);
        arg = bcd_digit(snap_score, dig_idx);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/rex_draw_sched.sv
// Per-frame draw-command scheduler. On an accepted frame_start it snapshots the
// game-centre outputs and streams CLEAR, ground HLINE, DINO, OBST (if visible),
// OVER (game over only) and optionally four score DIGITs over valid/ready.
// Optional feature macro: REX_SCORE_DRAW_EN adds score_bcd and DIGIT commands.
module rex_draw_sched
  import rex_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int GROUND_Y = DEF_GROUND_Y,
  parameter int DINO_X   = DEF_DINO_X,
  parameter int DINO_W   = DEF_DINO_W,
  parameter int DINO_H   = DEF_DINO_H,
  parameter int OBST_W   = DEF_OBST_W,
  parameter int OBST_H   = DEF_OBST_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        gpu_en,
  input  logic [1:0]  state,
  input  logic [15:0] dino_y,
  input  logic [15:0] obstacle_x,
`ifdef REX_SCORE_DRAW_EN
  input  logic [15:0] score_bcd,
`endif
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [15:0] cmd_x,
  output logic [15:0] cmd_y,
  output logic [15:0] cmd_w,
  output logic [15:0] cmd_h,
  output logic [3:0]  cmd_arg,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        frame_drop
);

  // State that follows the body of the frame (after OBST/OVER)
`ifdef REX_SCORE_DRAW_EN
  localparam draw_state_t TAIL_ST = S_DIGIT;
`else
  localparam draw_state_t TAIL_ST = S_IDLE;
`endif

  draw_state_t cur_st, nxt_st;
  logic [1:0]  snap_state;
  logic [15:0] snap_dino_y;
  logic [15:0] snap_obst_x;
`ifdef REX_SCORE_DRAW_EN
  logic [15:0] snap_score;
  logic [1:0]  dig_idx, nxt_dig;
`endif

  logic [2:0]  g_op;
  logic [15:0] g_x, g_y, g_w, g_h;
  logic [3:0]  g_arg;

  logic accept, hs, obst_vis, snap_over;

  // Game over still draws even with the game centre disabled
  assign accept    = (cur_st == S_IDLE) && frame_start && (gpu_en || (state == GS_OVER));
  assign hs        = cmd_valid && cmd_ready;
  assign obst_vis  = snap_obst_x < 16'(SCREEN_W);
  assign snap_over = snap_state == GS_OVER;

  // Geometry for the command that will be presented next cycle
  rex_geom #(
    .SCREEN_W(SCREEN_W),
    .GROUND_Y(GROUND_Y),
    .DINO_X  (DINO_X),
    .DINO_W  (DINO_W),
    .DINO_H  (DINO_H),
    .OBST_W  (OBST_W),
    .OBST_H  (OBST_H)
  ) u_geom (
    .st         (nxt_st),
    .snap_dino_y(snap_dino_y),
    .snap_obst_x(snap_obst_x),
`ifdef REX_SCORE_DRAW_EN
    .dig_idx    (nxt_dig),
    .snap_score (snap_score),
`endif
    .op         (g_op),
    .x          (g_x),
    .y          (g_y),
    .w          (g_w),
    .h          (g_h),
    .arg        (g_arg)
  );

  // Next state: advance one command per handshake, skipping absent commands
  always_comb begin
    nxt_st = cur_st;
`ifdef REX_SCORE_DRAW_EN
    nxt_dig = dig_idx;
`endif
    case (cur_st)
      S_IDLE:   if (accept) nxt_st = S_CLEAR;
      S_CLEAR:  if (hs) nxt_st = S_GROUND;
      S_GROUND: if (hs) nxt_st = S_DINO;
      S_DINO:   if (hs) nxt_st = obst_vis ? S_OBST : (snap_over ? S_OVER : TAIL_ST);
      S_OBST:   if (hs) nxt_st = snap_over ? S_OVER : TAIL_ST;
      S_OVER:   if (hs) nxt_st = TAIL_ST;
`ifdef REX_SCORE_DRAW_EN
      S_DIGIT: begin
        if (hs) begin
          if (dig_idx == 2'd3) nxt_st = S_IDLE;
          else                 nxt_dig = dig_idx + 2'd1;
        end
      end
`endif
      default:  nxt_st = S_IDLE;
    endcase
  end

  // FSM, snapshot and registered command outputs; fields only move on accept or handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_st      <= S_IDLE;
      snap_state  <= 2'd0;
      snap_dino_y <= 16'd0;
      snap_obst_x <= 16'd0;
`ifdef REX_SCORE_DRAW_EN
      snap_score  <= 16'd0;
      dig_idx     <= 2'd0;
`endif
      cmd_valid   <= 1'b0;
      cmd_op      <= 3'd0;
      cmd_x       <= 16'd0;
      cmd_y       <= 16'd0;
      cmd_w       <= 16'd0;
      cmd_h       <= 16'd0;
      cmd_arg     <= 4'd0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      cur_st     <= nxt_st;
`ifdef REX_SCORE_DRAW_EN
      dig_idx    <= (nxt_st == S_IDLE) ? 2'd0 : nxt_dig;
`endif
      frame_done <= 1'b0;
      frame_drop <= frame_start && frame_busy;
      if (accept) begin
        snap_state  <= state;
        snap_dino_y <= dino_y;
        snap_obst_x <= obstacle_x;
`ifdef REX_SCORE_DRAW_EN
        snap_score  <= score_bcd;
`endif
      end
      if (accept || hs) begin
        cmd_valid  <= nxt_st != S_IDLE;
        frame_busy <= nxt_st != S_IDLE;
        frame_done <= hs && (nxt_st == S_IDLE);
        cmd_op     <= g_op;
        cmd_x      <= g_x;
        cmd_y      <= g_y;
        cmd_w      <= g_w;
        cmd_h      <= g_h;
        cmd_arg    <= g_arg;
      end
    end
  end

endmodule

// File: tb/tb_rex_draw_sched.sv
// Testbench for rex_draw_sched. Drives frames and compares the handshaken
// command stream with a list-building reference model of the frame contents.
// Optional feature macro: REX_SCORE_DRAW_EN enables the score digit scenario.
`timescale 1ns/1ps
module tb_rex_draw_sched;

  localparam int SW = 256;
  localparam int GY = 200;
  localparam int DX = 16;
  localparam int DW = 16;
  localparam int DH = 16;
  localparam int OW = 16;
  localparam int OH = 26;

  typedef logic [70:0] cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        gpu_en = 1'b0;
  logic [1:0]  state = 2'd0;
  logic [15:0] dino_y = 16'd0;
  logic [15:0] obstacle_x = 16'd0;
`ifdef REX_SCORE_DRAW_EN
  logic [15:0] score_bcd = 16'd0;
`endif
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_x, cmd_y, cmd_w, cmd_h;
  logic [3:0]  cmd_arg;
  logic        frame_busy, frame_done, frame_drop;

  int   checks = 0;
  int   failures = 0;
  cmd_t exp_q[$];
  cmd_t obs_q[$];
  int   done_cyc, first_valid, hold_err, busy_err, drop_cyc;

  rex_draw_sched #(
    .SCREEN_W(SW), .GROUND_Y(GY), .DINO_X(DX), .DINO_W(DW),
    .DINO_H(DH), .OBST_W(OW), .OBST_H(OH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .gpu_en     (gpu_en),
    .state      (state),
    .dino_y     (dino_y),
    .obstacle_x (obstacle_x),
`ifdef REX_SCORE_DRAW_EN
    .score_bcd  (score_bcd),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_arg    (cmd_arg),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic cmd_t mk(input int op, input int x, input int y,
                              input int w, input int h, input int a);
    return {op[2:0], x[15:0], y[15:0], w[15:0], h[15:0], a[3:0]};
  endfunction

  // Reference: the ordered command list a frame with these inputs must produce
  task automatic model_frame(input int st, input int dy, input int ox);
    int lim;
    int yy;
    int room;
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0, SW, GY, 0));
    exp_q.push_back(mk(1, 0, GY, SW, 1, 0));
    lim = GY - DH;
    yy  = lim - ((dy > lim) ? lim : dy);
    exp_q.push_back(mk(2, DX, yy, DW, DH, 0));
    if (ox < SW) begin
      room = SW - ox;
      exp_q.push_back(mk(3, ox, GY - OH, (room < OW) ? room : OW, OH, 0));
    end
    if (st == 3) exp_q.push_back(mk(4, SW / 2 - 32, GY / 2, 64, 16, 0));
`ifdef REX_SCORE_DRAW_EN
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk(5, SW - 40 + 8 * i, 8, 8, 8, (int'(score_bcd) >> (12 - 4 * i)) & 15));
`endif
  endtask

  // Pulse frame_start and record handshaken commands; cycle 1 is the cycle after the pulse.
  // rmode: 0 always ready, 1 random ready with scrambled inputs, 2 stall 5 cycles on DINO
  task automatic collect(input int rmode, input int max_cyc, input int inject_c, input int abort_c);
    cmd_t cur;
    cmd_t prev;
    logic held;
    logic r;
    int   stall;
    obs_q.delete();
    done_cyc = -1; first_valid = -1; hold_err = 0; busy_err = 0; drop_cyc = -1;
    held = 1'b0; prev = '0; stall = 5;
    frame_start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= max_cyc; c++) begin
      frame_start = (c == inject_c);
      if (c == abort_c) return;
      cur = {cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_arg};
      if (frame_done) begin
        done_cyc = c;
        break;
      end
      if (frame_drop && drop_cyc < 0) drop_cyc = c;
      if (cmd_valid && first_valid < 0) first_valid = c;
      if (held && cur !== prev) hold_err++;
      if (cmd_valid !== frame_busy) busy_err++;
      case (rmode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          r = 1'b1;
          if (cmd_valid && cmd_op == 3'd2 && stall > 0) begin
            r = 1'b0;
            stall--;
          end
        end
      endcase
      cmd_ready = r;
      if (rmode == 1) begin
        dino_y     = 16'($urandom);
        obstacle_x = 16'($urandom);
        state      = 2'($urandom_range(0, 3));
        gpu_en     = 1'($urandom_range(0, 1));
      end
      if (cmd_valid && r) obs_q.push_back(cur);
      held = cmd_valid && !r;
      prev = cur;
      @(negedge clk);
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [75:0] outs;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    outs = {cmd_valid, frame_busy, frame_done, frame_drop, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_arg};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    outs = {cmd_valid, frame_busy, frame_done, frame_drop, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_arg};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL idle_after_reset got=%h exp=0", outs); end
  endtask

  task automatic test_basic();
    cmd_t lit[4];
    lit[0] = mk(0, 0, 0, 256, 200, 0);
    lit[1] = mk(1, 0, 200, 256, 1, 0);
    lit[2] = mk(2, 16, 184, 16, 16, 0);
    lit[3] = mk(3, 100, 174, 16, 26, 0);
    gpu_en = 1'b1; state = 2'd1; dino_y = 16'd0; obstacle_x = 16'd100;
    model_frame(1, 0, 100);
    collect(0, 40, 0, 0);
    checks++;
    if (first_valid !== 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1", first_valid); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== lit[i]) begin failures++; $display("FAIL basic_cmd%0d got=%h exp=%h", i, obs_q[i], lit[i]); end
    end
    checks++;
    if (done_cyc !== 5) begin failures++; $display("FAIL basic_done got=%0d exp=5", done_cyc); end
    checks++;
    if (busy_err !== 0) begin failures++; $display("FAIL basic_busy got=%0d exp=0", busy_err); end
  endtask

  task automatic test_stall();
    gpu_en = 1'b1; state = 2'd2; dino_y = 16'd36; obstacle_x = 16'd60;
    model_frame(2, 36, 60);
    collect(2, 40, 0, 0);
    checks++;
    if (obs_q !== exp_q) begin failures++; $display("FAIL stall_stream got=%0d cmds exp=%0d", obs_q.size(), exp_q.size()); end
    checks++;
    if (obs_q.size() > 2 && obs_q[2] !== mk(2, 16, 148, 16, 16, 0)) begin
      failures++; $display("FAIL stall_dino got=%h exp=%h", obs_q[2], mk(2, 16, 148, 16, 16, 0));
    end
    checks++;
    if (hold_err !== 0) begin failures++; $display("FAIL stall_hold got=%0d exp=0", hold_err); end
    checks++;
    if (done_cyc !== 10) begin failures++; $display("FAIL stall_done got=%0d exp=10", done_cyc); end
  endtask

  task automatic test_boundaries();
    int dys[5] = '{0, 0, 500, 184, 7};
    int oxs[5] = '{250, 256, 100, 240, 65535};
    for (int k = 0; k < 5; k++) begin
      gpu_en = 1'b1; state = 2'd1; dino_y = 16'(dys[k]); obstacle_x = 16'(oxs[k]);
      model_frame(1, dys[k], oxs[k]);
      collect(0, 40, 0, 0);
      checks++;
      if (obs_q !== exp_q) begin
        failures++;
        $display("FAIL bound%0d_stream got=%0d cmds last=%h exp=%0d cmds last=%h", k,
                 obs_q.size(), (obs_q.size() > 0) ? obs_q[$] : '0, exp_q.size(), exp_q[$]);
      end
      checks++;
      if (done_cyc !== exp_q.size() + 1) begin failures++; $display("FAIL bound%0d_done got=%0d exp=%0d", k, done_cyc, exp_q.size() + 1); end
    end
  endtask

  task automatic test_over();
    gpu_en = 1'b0; state = 2'd3; dino_y = 16'd20; obstacle_x = 16'd100;
    model_frame(3, 20, 100);
    collect(0, 40, 0, 0);
    checks++;
    if (obs_q !== exp_q) begin failures++; $display("FAIL over_stream got=%0d cmds exp=%0d", obs_q.size(), exp_q.size()); end
    checks++;
    if (obs_q.size() > 4 && obs_q[4] !== mk(4, 96, 100, 64, 16, 0)) begin
      failures++; $display("FAIL over_cmd got=%h exp=%h", obs_q[4], mk(4, 96, 100, 64, 16, 0));
    end
    gpu_en = 1'b0; state = 2'd3; dino_y = 16'd0; obstacle_x = 16'd300;
    model_frame(3, 0, 300);
    collect(0, 40, 0, 0);
    checks++;
    if (obs_q !== exp_q) begin failures++; $display("FAIL over_noobst got=%0d cmds exp=%0d", obs_q.size(), exp_q.size()); end
    gpu_en = 1'b0; state = 2'd0;
    collect(0, 10, 0, 0);
    checks++;
    if (first_valid !== -1 || done_cyc !== -1 || drop_cyc !== -1) begin
      failures++; $display("FAIL ignored_frame got valid@%0d done@%0d drop@%0d exp none", first_valid, done_cyc, drop_cyc);
    end
  endtask

  task automatic test_drop();
    gpu_en = 1'b1; state = 2'd1; dino_y = 16'd10; obstacle_x = 16'd30;
    model_frame(1, 10, 30);
    collect(0, 40, 2, 0);
    checks++;
    if (drop_cyc !== 3) begin failures++; $display("FAIL drop_pulse got=%0d exp=3", drop_cyc); end
    checks++;
    if (obs_q !== exp_q) begin failures++; $display("FAIL drop_stream got=%0d cmds exp=%0d", obs_q.size(), exp_q.size()); end
    checks++;
    if (done_cyc !== 5) begin failures++; $display("FAIL drop_done got=%0d exp=5", done_cyc); end
  endtask

  task automatic test_reset_mid();
    logic [75:0] outs;
    gpu_en = 1'b1; state = 2'd1; dino_y = 16'd5; obstacle_x = 16'd50;
    collect(0, 40, 0, 3);
    rst = 1'b0;
    #1;
    outs = {cmd_valid, frame_busy, frame_done, frame_drop, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_arg};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL midreset_outputs got=%h exp=0", outs); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || frame_busy !== 1'b0) begin
      failures++; $display("FAIL midreset_resumed got valid=%b busy=%b exp 0", cmd_valid, frame_busy);
    end
    dino_y = 16'd60; obstacle_x = 16'd245;
    model_frame(1, 60, 245);
    collect(0, 40, 0, 0);
    checks++;
    if (obs_q !== exp_q) begin failures++; $display("FAIL midreset_next got=%0d cmds exp=%0d", obs_q.size(), exp_q.size()); end
    checks++;
    if (done_cyc !== exp_q.size() + 1) begin failures++; $display("FAIL midreset_done got=%0d exp=%0d", done_cyc, exp_q.size() + 1); end
  endtask

  // Back-to-back frames: each new frame_start lands in the frame_done cycle
  task automatic test_back_to_back();
    int  st, dy, ox;
    logic en;
    for (int n = 0; n < 30; n++) begin
      st = $urandom_range(0, 3);
      en = 1'($urandom_range(0, 1));
      dy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 200);
      ox = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 65535) : $urandom_range(0, 270);
      state = 2'(st); gpu_en = en; dino_y = 16'(dy); obstacle_x = 16'(ox);
`ifdef REX_SCORE_DRAW_EN
      score_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
`endif
      if (en || st == 3) begin
        model_frame(st, dy, ox);
        collect(1, 200, 0, 0);
        checks++;
        if (obs_q !== exp_q || done_cyc < 0) begin
          failures++; $display("FAIL rand%0d_stream got=%0d cmds done@%0d exp=%0d cmds", n, obs_q.size(), done_cyc, exp_q.size());
        end
        checks++;
        if (hold_err !== 0 || busy_err !== 0) begin
          failures++; $display("FAIL rand%0d_handshake got hold=%0d busy=%0d exp 0", n, hold_err, busy_err);
        end
      end else begin
        collect(1, 6, 0, 0);
        checks++;
        if (first_valid !== -1 || obs_q.size() !== 0) begin
          failures++; $display("FAIL rand%0d_ignored got valid@%0d exp none", n, first_valid);
        end
      end
    end
  endtask

`ifdef REX_SCORE_DRAW_EN
  task automatic test_digits();
    int xs[4] = '{216, 224, 232, 240};
    int as[4] = '{0, 4, 2, 7};
    gpu_en = 1'b1; state = 2'd1; dino_y = 16'd0; obstacle_x = 16'd100; score_bcd = 16'h0427;
    model_frame(1, 0, 100);
    collect(0, 40, 0, 0);
    checks++;
    if (obs_q.size() !== 8) begin failures++; $display("FAIL digit_count got=%0d exp=8", obs_q.size()); end
    for (int i = 0; i < 4 && i + 4 < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i + 4] !== mk(5, xs[i], 8, 8, 8, as[i])) begin
        failures++; $display("FAIL digit%0d got=%h exp=%h", i, obs_q[i + 4], mk(5, xs[i], 8, 8, 8, as[i]));
      end
    end
    checks++;
    if (done_cyc !== 9) begin failures++; $display("FAIL digit_done got=%0d exp=9", done_cyc); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_boundaries();
    test_over();
    test_drop();
    test_reset_mid();
`ifdef REX_SCORE_DRAW_EN
    test_digits();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
